// File: rtl/roi_apb.sv
// APB3 zero-wait-state slave holding a two-corner region of interest.
// Ports: clk_i/arst_i (async active-low), APB slave bus, xy_0_o/xy_1_o corners.
module roi_apb #(
   parameter int APB_DATA_W = 32,
   parameter int APB_ADDR_W = 12
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic [APB_DATA_W-1:0] apb_pwdata_i,
   input  logic [APB_ADDR_W-1:0] apb_paddr_i,
   input  logic                  apb_pwrite_i,
   input  logic                  apb_psel_i,
   input  logic                  apb_penable_i,
   output logic [APB_DATA_W-1:0] apb_prdata_o,
   output logic                  apb_pready_o,
   output logic [APB_DATA_W-1:0] xy_0_o,
   output logic [APB_DATA_W-1:0] xy_1_o
);

   localparam int          IW = APB_ADDR_W - 2;
   localparam logic [31:0] ID = 32'h524F_4901;

   logic [9:0]            r_x0;
   logic [9:0]            r_y0;
   logic [9:0]            r_x1;
   logic [9:0]            r_y1;
   logic                  w_acc;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_valid;
   logic [IW-1:0]         w_idx;
   logic [APB_DATA_W-1:0] w_rdata;

   assign w_idx = apb_paddr_i[APB_ADDR_W-1:2];
   assign w_acc = apb_psel_i & apb_penable_i;
   assign w_wr  = w_acc & apb_pwrite_i;
   assign w_rd  = w_acc & ~apb_pwrite_i;

   assign w_valid = (r_x1 >= r_x0) && (r_y1 >= r_y0);

   assign xy_0_o = APB_DATA_W'({6'b0, r_y0, 6'b0, r_x0});
   assign xy_1_o = APB_DATA_W'({6'b0, r_y1, 6'b0, r_x1});

   assign apb_pready_o = w_acc;
   assign apb_prdata_o = w_rdata;

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_x0 <= '0;
         r_y0 <= '0;
         r_x1 <= '0;
         r_y1 <= '0;
      end else if (w_wr) begin
         if (w_idx == IW'(0)) begin
            r_x0 <= apb_pwdata_i[9:0];
            r_y0 <= apb_pwdata_i[25:16];
         end else if (w_idx == IW'(1)) begin
            r_x1 <= apb_pwdata_i[9:0];
            r_y1 <= apb_pwdata_i[25:16];
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_rd) begin
         unique case (1'b1)
            (w_idx == IW'(0)): w_rdata = xy_0_o;
            (w_idx == IW'(1)): w_rdata = xy_1_o;
            (w_idx == IW'(2)): w_rdata = APB_DATA_W'(w_valid);
            (w_idx == IW'(3)): w_rdata = APB_DATA_W'(ID);
            default:           w_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_roi_apb.sv
// Directed testbench for roi_apb.
// Hand-computed vectors checked through a single chk task.
module tb_roi_apb;

   logic        clk_i;
   logic        arst_i;
   logic [31:0] apb_pwdata_i;
   logic [11:0] apb_paddr_i;
   logic        apb_pwrite_i;
   logic        apb_psel_i;
   logic        apb_penable_i;
   logic [31:0] apb_prdata_o;
   logic        apb_pready_o;
   logic [31:0] xy_0_o;
   logic [31:0] xy_1_o;

   int n_chk;
   int n_err;

   roi_apb #(.APB_DATA_W(32), .APB_ADDR_W(12)) dut (
      .clk_i         (clk_i),
      .arst_i        (arst_i),
      .apb_pwdata_i  (apb_pwdata_i),
      .apb_paddr_i   (apb_paddr_i),
      .apb_pwrite_i  (apb_pwrite_i),
      .apb_psel_i    (apb_psel_i),
      .apb_penable_i (apb_penable_i),
      .apb_prdata_o  (apb_prdata_o),
      .apb_pready_o  (apb_pready_o),
      .xy_0_o        (xy_0_o),
      .xy_1_o        (xy_1_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
      tick();
      apb_psel_i    = 1'b1;
      apb_penable_i = 1'b0;
      apb_pwrite_i  = 1'b1;
      apb_paddr_i   = a;
      apb_pwdata_i  = d;
      tick();
      apb_penable_i = 1'b1;
      #1;
      chk("wr_pready", 32'(apb_pready_o), 32'd1);
      chk("wr_prdata", apb_prdata_o, 32'd0);
      tick();
      apb_psel_i    = 1'b0;
      apb_penable_i = 1'b0;
      apb_pwrite_i  = 1'b0;
      #1;
      chk("idle_pready", 32'(apb_pready_o), 32'd0);
   endtask

   task automatic apb_rd(input string tag, input logic [11:0] a,
                         input logic [31:0] exp);
      tick();
      apb_psel_i    = 1'b1;
      apb_penable_i = 1'b0;
      apb_pwrite_i  = 1'b0;
      apb_paddr_i   = a;
      #1;
      chk("setup_prdata", apb_prdata_o, 32'd0);
      tick();
      apb_penable_i = 1'b1;
      #1;
      chk("rd_pready", 32'(apb_pready_o), 32'd1);
      chk(tag, apb_prdata_o, exp);
      tick();
      apb_psel_i    = 1'b0;
      apb_penable_i = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      arst_i        = 1'b0;
      apb_pwdata_i  = '0;
      apb_paddr_i   = '0;
      apb_pwrite_i  = 1'b0;
      apb_psel_i    = 1'b0;
      apb_penable_i = 1'b0;

      // reset and idle
      tick();
      tick();
      chk("rst_xy0", xy_0_o, 32'd0);
      chk("rst_xy1", xy_1_o, 32'd0);
      chk("rst_prdata", apb_prdata_o, 32'd0);
      chk("rst_pready", 32'(apb_pready_o), 32'd0);
      arst_i = 1'b1;
      apb_rd("rst_status", 12'h008, 32'h1);

      // XY0 write and readback
      apb_wr(12'h000, 32'h00C8_00C8);
      chk("xy0_200", xy_0_o, 32'h00C8_00C8);
      apb_rd("rd_xy0_200", 12'h000, 32'h00C8_00C8);

      // XY1 and status
      apb_wr(12'h004, 32'h0190_00C8);
      chk("xy1_400", xy_1_o, 32'h0190_00C8);
      apb_rd("status_ok", 12'h008, 32'h1);
      apb_wr(12'h004, 32'h0064_00C8);
      chk("xy1_100", xy_1_o, 32'h0064_00C8);
      apb_rd("status_bad", 12'h008, 32'h0);

      // masking, ID, unmapped
      apb_wr(12'h000, 32'hFFFF_FFFF);
      chk("xy0_mask", xy_0_o, 32'h03FF_03FF);
      apb_rd("rd_xy0_mask", 12'h000, 32'h03FF_03FF);
      apb_wr(12'h010, 32'h1234_5678);
      apb_wr(12'h00C, 32'h0000_0001);
      chk("unmap_xy0", xy_0_o, 32'h03FF_03FF);
      chk("unmap_xy1", xy_1_o, 32'h0064_00C8);
      apb_rd("rd_id", 12'h00C, 32'h524F_4901);
      apb_rd("rd_id_lsb", 12'h00F, 32'h524F_4901);
      apb_rd("rd_unmap", 12'h010, 32'h0);
      apb_rd("rd_top", 12'hFFC, 32'h0);
      apb_rd("rd_xy1_lsb", 12'h005, 32'h0064_00C8);

      // setup-phase-only write has no effect
      tick();
      apb_psel_i   = 1'b1;
      apb_pwrite_i = 1'b1;
      apb_paddr_i  = 12'h000;
      apb_pwdata_i = 32'h0000_0005;
      tick();
      apb_psel_i   = 1'b0;
      apb_pwrite_i = 1'b0;
      tick();
      chk("setup_only", xy_0_o, 32'h03FF_03FF);

      // back-to-back write then read with psel held
      tick();
      apb_psel_i   = 1'b1;
      apb_pwrite_i = 1'b1;
      apb_paddr_i  = 12'h000;
      apb_pwdata_i = 32'h0001_0002;
      tick();
      apb_penable_i = 1'b1;
      tick();
      apb_penable_i = 1'b0;
      apb_pwrite_i  = 1'b0;
      #1;
      chk("b2b_xy0", xy_0_o, 32'h0001_0002);
      chk("b2b_gap_rdy", 32'(apb_pready_o), 32'd0);
      tick();
      apb_penable_i = 1'b1;
      #1;
      chk("b2b_rd", apb_prdata_o, 32'h0001_0002);
      tick();
      apb_psel_i    = 1'b0;
      apb_penable_i = 1'b0;

      // reset pulse clears, then rewrite
      tick();
      arst_i = 1'b0;
      #1;
      chk("pulse_xy0", xy_0_o, 32'd0);
      chk("pulse_xy1", xy_1_o, 32'd0);
      tick();
      tick();
      arst_i = 1'b1;
      apb_rd("pulse_status", 12'h008, 32'h1);
      apb_wr(12'h000, 32'h0190_00C8);
      chk("post_rst_xy0", xy_0_o, 32'h0190_00C8);

      // reset during access phase aborts the write
      apb_wr(12'h004, 32'h0005_0005);
      chk("pre_abort_xy1", xy_1_o, 32'h0005_0005);
      tick();
      apb_psel_i   = 1'b1;
      apb_pwrite_i = 1'b1;
      apb_paddr_i  = 12'h004;
      apb_pwdata_i = 32'h0123_0045;
      tick();
      apb_penable_i = 1'b1;
      #2;
      arst_i = 1'b0;
      #1;
      chk("abort_async", xy_1_o, 32'd0);
      tick();
      chk("abort_edge", xy_1_o, 32'd0);
      apb_psel_i    = 1'b0;
      apb_penable_i = 1'b0;
      apb_pwrite_i  = 1'b0;
      tick();
      arst_i = 1'b1;
      tick();
      tick();
      chk("abort_xy1", xy_1_o, 32'd0);
      chk("abort_xy0", xy_0_o, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/roi_apb.md
Name: roi_apb

Overview:
APB3-style slave register block that holds a rectangular region-of-interest (ROI), defined by two corner points. The block has zero wait states. Each corner is a packed {y, x} pair of 10-bit coordinates and is driven continuously onto xy_0_o (first corner) and xy_1_o (second corner) for downstream image-processing logic. A status register reports whether the programmed ROI is well-formed, and an ID register allows software probing.

Parameters:
APB_DATA_W, 32, APB data bus width. Register layout assumes 32.
APB_ADDR_W, 12, APB address width. This covers a 4 KB slave window.

Ports:
clk_i  input  1  system/APB clock; all state updates on its rising edge
arst_i  input  1  asynchronous reset, active-low (asserted when 0)
apb_pwdata_i  input  APB_DATA_W  write data
apb_paddr_i  input  APB_ADDR_W  byte address
apb_pwrite_i  input  1  1 = write, 0 = read
apb_psel_i  input  1  slave select
apb_penable_i  input  1  access-phase indicator
apb_prdata_o  output  APB_DATA_W  read data
apb_pready_o  output  1  transfer-complete indicator
xy_0_o  output  APB_DATA_W  ROI corner 0: {6'b0, y0[9:0], 6'b0, x0[9:0]}
xy_1_o  output  APB_DATA_W  ROI corner 1: {6'b0, y1[9:0], 6'b0, x1[9:0]}

Behaviour:
- Register map (decode on paddr[APB_ADDR_W-1:2]; paddr[1:0] ignored):
  - 0x000 XY0 RW: x0 in [9:0], y0 in [25:16]; all other bits read as 0 and ignore writes.
  - 0x004 XY1 RW: same layout, holds x1 and y1.
  - 0x008 STATUS RO: bit0 = VALID = (x1 >= x0) && (y1 >= y0), unsigned compare. Bits [31:1] read as 0.
  - 0x00C ID RO: constant 0x524F_4901.
  - All other addresses: reads return 0, writes are ignored. No error response.
- Handshake:
  - Setup phase is psel=1, penable=0. Access phase is psel=1, penable=1.
  - apb_pready_o = psel & penable, combinational. Every transfer completes in the first access cycle, with no wait states.
  - apb_pready_o is 0 outside the access phase.
- Write:
  - At the rising edge where psel & penable & pwrite, the masked pwdata is stored into the addressed RW register.
  - The new value appears on xy_0_o / xy_1_o immediately after that edge (1-cycle latency from access-phase start).
  - A write during the setup phase alone has no effect.
- Read:
  - apb_prdata_o is combinationally decoded from paddr while psel & penable & !pwrite, and is 0 otherwise.
  - Reading XY0/XY1 returns exactly the value currently on xy_0_o/xy_1_o.
- Outputs:
  - xy_0_o and xy_1_o are direct register outputs. They are stable between writes and never glitch on reads.
  - STATUS is derived combinationally from the stored registers.
- Reset:
  - While arst_i=0, XY0 and XY1 are 0, so xy_0_o = xy_1_o = 0, apb_prdata_o = 0 and STATUS.VALID = 1 (0 >= 0).
  - Reset applied mid-transfer aborts the write, and registers go to 0 immediately (asynchronously).
  - Transfers are accepted from the first clock edge after arst_i returns to 1.
- Back-to-back transfers (penable dropped for one cycle, psel held) are supported.
- A second write to the same register overwrites the first.
- Coordinates are not clamped: any 10-bit value 0..1023 is stored as written.

Test Plan:
- Reset then idle: arst_i=0 for 2 cycles -> xy_0_o=0, xy_1_o=0, read 0x008 = 0x1.
- Write 0x000 = {6'd0,10'd200,6'd0,10'd200} (0x00C8_00C8) -> pready=1 in the access cycle; xy_0_o=0x00C8_00C8 after that edge; read 0x000 returns 0x00C8_00C8.
- Write 0x004 = 0x0190_00C8 (y=400, x=200) with XY0=(200,200) -> xy_1_o=0x0190_00C8; STATUS=1. Then write 0x004 = 0x0064_00C8 (y=100) -> STATUS=0.
- Write 0xFFFF_FFFF to 0x000 -> xy_0_o=0x03FF_03FF; write to 0x010 or 0x00C -> no register changes; read 0x00C = 0x524F_4901; read 0x010 = 0.
- Program XY0, pulse arst_i=0 for 2 cycles, then write 0x000 = 0x0190_00C8 -> outputs cleared to 0 during reset, then xy_0_o=0x0190_00C8.
- Assert arst_i=0 during the access phase of a write to 0x004 -> xy_1_o stays 0 and no write is committed.
